// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bundle of the SPI master sequencer.
// Transfer requests flow in; busy/rx results flow back out.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic [1:0]            i_rate;
    logic                  i_keep_cs;
    logic                  i_cs_release;
    logic                  o_busy;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;

    modport master (
        output i_start, i_tx_data, i_rate, i_keep_cs, i_cs_release,
        input  o_busy, o_rx_data, o_rx_valid
    );

    modport slave (
        input  i_start, i_tx_data, i_rate, i_keep_cs, i_cs_release,
        output o_busy, o_rx_data, o_rx_valid
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: CS timing, divider control, MSB-first shift.
// Supports bursts with CS held low between words.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    spi_master_ctrl_if.slave     host,
    output logic                 o_sclk_en,
    output logic [1:0]           o_sclk_rate,
    input  logic                 i_sclk_rise,
    input  logic                 i_sclk_fall,
    output logic                 o_cs_n,
    output logic                 o_mosi,
    input  logic                 i_miso
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam int BW   = $clog2(DATA_WIDTH + 1);
    localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH);

    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  keep;
    logic                  busy;
    logic                  rx_valid;

    assign host.o_busy     = busy;
    assign host.o_rx_data  = rx_data;
    assign host.o_rx_valid = rx_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_data     <= '0;
            keep        <= 1'b0;
            busy        <= 1'b0;
            rx_valid    <= 1'b0;
            o_cs_n      <= 1'b1;
            o_sclk_en   <= 1'b0;
            o_sclk_rate <= 2'b00;
            o_mosi      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy marks the accept cycle; CS drops one cycle later
                    if (busy) begin
                        o_cs_n <= 1'b0;
                        o_mosi <= tx_sh[DATA_WIDTH-1];
                        cnt    <= '0;
                        state  <= S_SETUP;
                    end else if (host.i_start) begin
                        tx_sh       <= host.i_tx_data;
                        o_sclk_rate <= host.i_rate;
                        keep        <= host.i_keep_cs;
                        busy        <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        o_sclk_en <= 1'b1;
                        bitcnt    <= '0;
                        state     <= S_XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    unique case (1'b1)
                        i_sclk_rise: begin
                            if (bitcnt != BIT_LAST) begin
                                rx_sh  <= {rx_sh[DATA_WIDTH-2:0], i_miso};
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                        i_sclk_fall: begin
                            if (bitcnt == BIT_LAST) begin
                                o_sclk_en <= 1'b0;
                                rx_data   <= rx_sh;
                                rx_valid  <= 1'b1;
                                o_mosi    <= 1'b0;
                                cnt       <= '0;
                                busy      <= ~keep;
                                state     <= keep ? S_WAIT : S_HOLD;
                            end else begin
                                tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
                                o_mosi <= tx_sh[DATA_WIDTH-2];
                            end
                        end
                        default: ;
                    endcase
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        o_cs_n <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // CS is already low, so the next word skips setup
                    if (host.i_start) begin
                        tx_sh       <= host.i_tx_data;
                        o_sclk_rate <= host.i_rate;
                        keep        <= host.i_keep_cs;
                        o_mosi      <= host.i_tx_data[DATA_WIDTH-1];
                        o_sclk_en   <= 1'b1;
                        bitcnt      <= '0;
                        busy        <= 1'b1;
                        state       <= S_XFER;
                    end else if (host.i_cs_release) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_HOLD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural SCLK divider.
// Random words/rates/MISO are checked against bit-level expectations.
module tb_spi_master_ctrl;
    localparam int W     = 8;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_en;
    logic [1:0] sclk_rate;
    logic rise;
    logic fall;
    logic cs_n;
    logic mosi;
    logic miso;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    spi_master_ctrl_if #(.DATA_WIDTH(W)) bus ();

    spi_master_ctrl #(
        .DATA_WIDTH(W),
        .CS_SETUP(SETUP),
        .CS_HOLD(HOLD)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .host(bus),
        .o_sclk_en(sclk_en),
        .o_sclk_rate(sclk_rate),
        .i_sclk_rise(rise),
        .i_sclk_fall(fall),
        .o_cs_n(cs_n),
        .o_mosi(mosi),
        .i_miso(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // divider model: SCLK half period = 2^rate cycles, starts low
    int   dcnt = 0;
    logic sclk = 1'b0;
    int   half;
    assign half = 1 << sclk_rate;
    assign rise = sclk_en && (dcnt == half - 1) && !sclk;
    assign fall = sclk_en && (dcnt == half - 1) && sclk;

    always @(posedge clk) begin
        if (!sclk_en) begin
            dcnt <= 0;
            sclk <= 1'b0;
        end else if (dcnt == half - 1) begin
            dcnt <= 0;
            sclk <= ~sclk;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    int   miso_mode = 0;
    logic rnd = 1'b0;
    always @(posedge clk) rnd <= 1'($urandom_range(0, 1));
    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : rnd;

    // monitor: bit streams at each SCLK rise, edge timestamps
    int          rises = 0;
    int          vcnt = 0;
    int          csrises = 0;
    int          t_csfall = 0;
    int          t_csrise = 0;
    int          t_enrise = 0;
    int          t_lastfall = 0;
    logic [15:0] mosi_sh = '0;
    logic [15:0] miso_sh = '0;
    logic        prev_cs = 1'b1;
    logic        prev_en = 1'b0;

    always @(negedge clk) begin
        if (rise) begin
            rises++;
            mosi_sh = {mosi_sh[14:0], mosi};
            miso_sh = {miso_sh[14:0], miso};
        end
        if (fall) t_lastfall = cyc;
        if (bus.o_rx_valid) vcnt++;
        if (prev_cs && !cs_n) t_csfall = cyc;
        if (!prev_cs && cs_n) begin
            t_csrise = cyc;
            csrises++;
        end
        if (!prev_en && sclk_en) t_enrise = cyc;
        prev_cs = cs_n;
        prev_en = sclk_en;
    end

    int t_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic [7:0] tx, input logic [1:0] rate,
                               input logic keep, input logic rel);
        @(negedge clk);
        bus.i_start      = 1'b1;
        bus.i_tx_data    = tx;
        bus.i_rate       = rate;
        bus.i_keep_cs    = keep;
        bus.i_cs_release = rel;
        t_start          = cyc;
        @(negedge clk);
        bus.i_start      = 1'b0;
        bus.i_cs_release = 1'b0;
        bus.i_tx_data    = 8'($urandom);
        bus.i_rate       = 2'($urandom);
        bus.i_keep_cs    = 1'($urandom);
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] tx,
                            input logic [1:0] rate, input logic keep,
                            input logic rel);
        int rb;
        int vb;
        logic found;
        logic [7:0] got;
        rb = rises;
        vb = vcnt;
        drive_start(tx, rate, keep, rel);
        found = 1'b0;
        got = '0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (bus.o_rx_valid) begin
                found = 1'b1;
                got = bus.o_rx_data;
            end
        end
        chk({tag, "_done"}, 32'(found), 32'd1);
        chk({tag, "_rx"}, 32'(got), 32'(miso_sh[7:0]));
        chk({tag, "_mosi"}, 32'(mosi_sh[7:0]), 32'(tx));
        chk({tag, "_rises"}, 32'(rises - rb), 32'(W));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(vcnt - vb), 32'd1);
        chk({tag, "_vlow"}, 32'(bus.o_rx_valid), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!bus.o_busy && cs_n) ok = 1'b1;
        end
        chk({tag, "_idle"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int rb;
        int csb;
        int t_rel;
        logic [7:0] tx;
        logic [1:0] rt;
        bus.i_start      = 1'b0;
        bus.i_tx_data    = '0;
        bus.i_rate       = '0;
        bus.i_keep_cs    = 1'b0;
        bus.i_cs_release = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs_n), 32'd1);
        chk("rst_en", 32'(sclk_en), 32'd0);
        chk("rst_rate", 32'(sclk_rate), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_valid", 32'(bus.o_rx_valid), 32'd0);
        chk("rst_rxd", 32'(bus.o_rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        miso_mode = 0;
        run_xfer("a5", 8'hA5, 2'b01, 1'b0, 1'b0);
        chk("a5_loop", 32'(bus.o_rx_data), 32'h0A5);
        chk("setup_gap", 32'(t_enrise - t_csfall), 32'(SETUP));
        wait_idle("a5");
        chk("hold_gap", 32'(t_csrise - t_lastfall), 32'(HOLD + 1));

        miso_mode = 1;
        for (int r = 0; r < 4; r++) begin
            run_xfer("sweep", 8'h3C, 2'(r), 1'b0, 1'b0);
            chk("sweep_ff", 32'(bus.o_rx_data), 32'h0FF);
            chk("sweep_rate", 32'(sclk_rate), 32'(r));
            wait_idle("sweep");
        end

        miso_mode = 2;
        csb = csrises;
        run_xfer("b12", 8'h12, 2'b00, 1'b1, 1'b0);
        chk("wait_busy", 32'(bus.o_busy), 32'd0);
        chk("wait_cs", 32'(cs_n), 32'd0);
        run_xfer("b34", 8'h34, 2'b01, 1'b0, 1'b0);
        chk("b34_nosetup", 32'(t_enrise - t_start), 32'd1);
        chk("burst_cs_low", 32'(csrises - csb), 32'd0);
        wait_idle("b34");
        chk("burst_cs_up", 32'(csrises - csb), 32'd1);

        run_xfer("r5a", 8'h5A, 2'b10, 1'b1, 1'b0);
        @(negedge clk);
        bus.i_cs_release = 1'b1;
        t_rel = cyc;
        @(negedge clk);
        bus.i_cs_release = 1'b0;
        chk("rel_busy", 32'(bus.o_busy), 32'd1);
        wait_idle("rel");
        chk("rel_gap", 32'(t_csrise - t_rel), 32'(HOLD + 1));

        run_xfer("sc3", 8'hC3, 2'b00, 1'b1, 1'b0);
        csb = csrises;
        run_xfer("s96", 8'h96, 2'b11, 1'b0, 1'b1);
        chk("both_nosetup", 32'(t_enrise - t_start), 32'd1);
        chk("both_cs_low", 32'(csrises - csb), 32'd0);
        wait_idle("s96");

        rb = rises;
        drive_start(8'hE7, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 500 && (rises - rb) < 3; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_cs", 32'(cs_n), 32'd1);
        chk("mid_en", 32'(sclk_en), 32'd0);
        chk("mid_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_mosi", 32'(mosi), 32'd0);
        chk("mid_rxd", 32'(bus.o_rx_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_xfer("post", 8'h69, 2'b01, 1'b0, 1'b0);
        wait_idle("post");

        for (int k = 0; k < 8; k++) begin
            tx = 8'($urandom);
            rt = 2'($urandom_range(0, 3));
            miso_mode = int'($urandom_range(0, 2));
            run_xfer("rand", tx, rt, 1'b0, 1'b0);
            if (miso_mode == 0) chk("rand_loop", 32'(bus.o_rx_data), 32'(tx));
            wait_idle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
